// File: rtl/theremin_sensor_pkg.sv
// Shared definitions for the theremin IIR sequencer.
//   seq_state_t        : sequencer FSM states
//   DEF_DATA_BITS      : default sample/state width
//   DEF_FILTER_K_SHIFT : default IIR coefficient shift
//   DEF_MAX_STAGES     : default stage slots per channel
package theremin_sensor_pkg;

  localparam int DEF_DATA_BITS      = 32;
  localparam int DEF_FILTER_K_SHIFT = 8;
  localparam int DEF_MAX_STAGES     = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN_A = 3'd2,
    ST_RUN_B = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/theremin_iir_stage_update.sv
// One-pole IIR stage update, purely combinational:
//   upd = prime ? x : s + ((x - s) >>> FILTER_K_SHIFT)
// Ports:
//   s     in  DATA_BITS  current stage state
//   x     in  DATA_BITS  stage input
//   prime in  1          load x directly instead of filtering
//   upd   out DATA_BITS  new stage state
module theremin_iir_stage_update
  import theremin_sensor_pkg::*;
#(
  parameter int DATA_BITS      = DEF_DATA_BITS,
  parameter int FILTER_K_SHIFT = DEF_FILTER_K_SHIFT
) (
  input  logic signed [DATA_BITS-1:0] s,
  input  logic signed [DATA_BITS-1:0] x,
  input  logic                        prime,
  output logic signed [DATA_BITS-1:0] upd
);

  // One extra bit so full-scale swings do not wrap before the shift.
  logic signed [DATA_BITS:0] diff;
  logic signed [DATA_BITS:0] step;

  assign diff = {x[DATA_BITS-1], x} - {s[DATA_BITS-1], s};
  assign step = diff >>> FILTER_K_SHIFT;
  assign upd  = prime ? x : DATA_BITS'(s + step);

endmodule

// File: rtl/theremin_iir_sequencer.sv
// Two-channel cascaded IIR smoother for theremin pitch/volume periods.
// A single stage-update datapath is time-shared: channel A stages 0..M,
// then channel B stages 0..M, one stage per cycle.
// Ports:
//   CLK            in   1          clock
//   RESET_N        in   1          synchronous active-low reset
//   MAX_STAGE      in   3          stage count minus one (M)
//   IN_STROBE      in   1          new sample pair available
//   IN_VALUE_A/B   in   DATA_BITS  pitch / volume period samples
//   BUSY           out  1          high while not idle
//   OUT_VALID      out  1          one-cycle pulse when outputs update
//   OUT_VALUE_A/B  out  DATA_BITS  filtered pitch / volume values
//   OVERRUN_COUNT  out  8          dropped strobes, saturating
module theremin_iir_sequencer
  import theremin_sensor_pkg::*;
#(
  parameter int DATA_BITS      = DEF_DATA_BITS,
  parameter int FILTER_K_SHIFT = DEF_FILTER_K_SHIFT,
  parameter int MAX_STAGES     = DEF_MAX_STAGES
) (
  input  logic                        CLK,
  input  logic                        RESET_N,
  input  logic [2:0]                  MAX_STAGE,
  input  logic                        IN_STROBE,
  input  logic signed [DATA_BITS-1:0] IN_VALUE_A,
  input  logic signed [DATA_BITS-1:0] IN_VALUE_B,
  output logic                        BUSY,
  output logic                        OUT_VALID,
  output logic signed [DATA_BITS-1:0] OUT_VALUE_A,
  output logic signed [DATA_BITS-1:0] OUT_VALUE_B,
  output logic [7:0]                  OVERRUN_COUNT
);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  seq_state_t state_q, state_d;

  logic signed [DATA_BITS-1:0] st_mem [2][MAX_STAGES];
  logic signed [DATA_BITS-1:0] x_p0, cap_b_p0, s_cur, upd;
  logic signed [DATA_BITS-1:0] out_a_q, out_b_q;
  logic [2:0]                  cap_m_p0, stg_p0, last_m;
  logic                        prime_p0, primed, ch, last_stg;
  logic [7:0]                  ovr_q;

  assign ch       = (state_q == ST_RUN_B);
  assign s_cur    = st_mem[ch][stg_p0];
  assign last_stg = (stg_p0 == cap_m_p0);

  assign BUSY          = (state_q != ST_IDLE);
  assign OUT_VALID     = (state_q == ST_DONE);
  assign OUT_VALUE_A   = out_a_q;
  assign OUT_VALUE_B   = out_b_q;
  assign OVERRUN_COUNT = ovr_q;

  theremin_iir_stage_update #(
    .DATA_BITS      (DATA_BITS),
    .FILTER_K_SHIFT (FILTER_K_SHIFT)
  ) u_stage (
    .s     (s_cur),
    .x     (x_p0),
    .prime (prime_p0),
    .upd   (upd)
  );

  always_ff @(posedge CLK) begin
    if (!RESET_N) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (IN_STROBE) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_RUN_A;
      ST_RUN_A: if (last_stg) state_d = ST_RUN_B;
      ST_RUN_B: if (last_stg) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      for (int c = 0; c < 2; c++)
        for (int i = 0; i < MAX_STAGES; i++)
          st_mem[c][i] <= '0;
      x_p0     <= '0;
      cap_b_p0 <= '0;
      cap_m_p0 <= '0;
      stg_p0   <= '0;
      prime_p0 <= 1'b0;
      primed   <= 1'b0;
      last_m   <= '0;
      out_a_q  <= '0;
      out_b_q  <= '0;
      ovr_q    <= '0;
    end else begin
      // Any strobe outside IDLE (including DONE) is dropped.
      if (IN_STROBE && state_q != ST_IDLE) ovr_q <= sat_inc8(ovr_q);

      case (state_q)
        // p0: capture sample pair and stage count for the whole pass
        ST_LOAD: begin
          x_p0     <= IN_VALUE_A;
          cap_b_p0 <= IN_VALUE_B;
          cap_m_p0 <= MAX_STAGE;
          stg_p0   <= '0;
          prime_p0 <= !primed || (MAX_STAGE != last_m);
        end
        // p1: one stage per cycle; each result feeds the next stage
        ST_RUN_A, ST_RUN_B: begin
          st_mem[ch][stg_p0] <= upd;
          if (last_stg) begin
            stg_p0 <= '0;
            if (state_q == ST_RUN_A) begin
              x_p0 <= cap_b_p0;
            end else begin
              out_a_q <= st_mem[0][cap_m_p0];
              out_b_q <= upd;
              primed  <= 1'b1;
              last_m  <= cap_m_p0;
            end
          end else begin
            stg_p0 <= stg_p0 + 3'd1;
            x_p0   <= upd;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_theremin_iir_sequencer.sv
module tb_theremin_iir_sequencer;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [2:0]  MAX_STAGE;
  logic        IN_STROBE;
  logic [31:0] IN_VALUE_A, IN_VALUE_B;
  logic        BUSY, OUT_VALID;
  logic [31:0] OUT_VALUE_A, OUT_VALUE_B;
  logic [7:0]  OVERRUN_COUNT;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 CLK = ~CLK;

  theremin_iir_sequencer dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .MAX_STAGE     (MAX_STAGE),
    .IN_STROBE     (IN_STROBE),
    .IN_VALUE_A    (IN_VALUE_A),
    .IN_VALUE_B    (IN_VALUE_B),
    .BUSY          (BUSY),
    .OUT_VALID     (OUT_VALID),
    .OUT_VALUE_A   (OUT_VALUE_A),
    .OUT_VALUE_B   (OUT_VALUE_B),
    .OVERRUN_COUNT (OVERRUN_COUNT)
  );

  typedef struct {
    logic [2:0]  m;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ea;
    logic [31:0] eb;
    int          lat;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Inputs stay at the given values after the strobe so LOAD sees them.
  task automatic send(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b);
    MAX_STAGE  = m;
    IN_VALUE_A = a;
    IN_VALUE_B = b;
    IN_STROBE  = 1'b1;
    tick();
    IN_STROBE  = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (!OUT_VALID && n < 60) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n, k;
    logic seen;

    vecs[0] = '{3'd0, 32'h1000_0000, 32'h2000_0000, 32'h1000_0000, 32'h2000_0000, 4};
    vecs[1] = '{3'd0, 32'h1000_0100, 32'h2000_0000, 32'h1000_0001, 32'h2000_0000, 4};
    vecs[2] = '{3'd1, 32'h1000_0000, 32'h2000_0000, 32'h1000_0000, 32'h2000_0000, 6};
    vecs[3] = '{3'd1, 32'h0FFF_FF00, 32'h2000_0000, 32'h0FFF_FFFF, 32'h2000_0000, 6};
    vecs[4] = '{3'd0, 32'h1000_0000, 32'h0000_0100, 32'h1000_0000, 32'h0000_0100, 4};
    vecs[5] = '{3'd0, 32'h0FFF_FF00, 32'h0000_0000, 32'h0FFF_FFFF, 32'h0000_00FF, 4};
    vecs[6] = '{3'd0, 32'h1000_0000, 32'h0000_0000, 32'h0FFF_FFFF, 32'h0000_00FE, 4};
    vecs[7] = '{3'd7, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 18};
    vecs[8] = '{3'd7, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFE, 32'h8000_0000, 18};

    RESET_N    = 1'b0;
    MAX_STAGE  = 3'd0;
    IN_STROBE  = 1'b0;
    IN_VALUE_A = '0;
    IN_VALUE_B = '0;
    repeat (3) tick();
    chk("rst_busy",  BUSY, 0);
    chk("rst_valid", OUT_VALID, 0);
    chk("rst_out_a", OUT_VALUE_A, 0);
    chk("rst_out_b", OUT_VALUE_B, 0);
    chk("rst_ovr",   OVERRUN_COUNT, 0);
    RESET_N = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      send(vecs[i].m, vecs[i].a, vecs[i].b);
      wait_valid(n);
      chk($sformatf("v%0d_lat", i), n, vecs[i].lat);
      chk($sformatf("v%0d_out_a", i), OUT_VALUE_A, vecs[i].ea);
      chk($sformatf("v%0d_out_b", i), OUT_VALUE_B, vecs[i].eb);
      tick();
      chk($sformatf("v%0d_pulse_end", i), OUT_VALID, 0);
      tick();
    end

    repeat (3) tick();
    chk("hold_valid", OUT_VALID, 0);
    chk("hold_out_a", OUT_VALUE_A, 32'h7FFF_FFFE);
    chk("hold_out_b", OUT_VALUE_B, 32'h8000_0000);
    chk("hold_busy",  BUSY, 0);

    // Mid-run input changes must not affect the pass already loaded.
    send(3'd0, 32'h0000_1000, 32'h0);
    tick();
    MAX_STAGE  = 3'd3;
    IN_VALUE_A = 32'h0000_FFFF;
    n = 2;
    while (!OUT_VALID && n < 60) begin
      tick();
      n++;
    end
    chk("mchg_lat", n, 4);
    chk("mchg_out_a", OUT_VALUE_A, 32'h0000_1000);
    repeat (2) tick();
    send(3'd3, 32'h0000_0040, 32'h0);
    wait_valid(n);
    chk("reprime_lat", n, 10);
    chk("reprime_out_a", OUT_VALUE_A, 32'h0000_0040);
    chk("reprime_out_b", OUT_VALUE_B, 32'h0);
    repeat (2) tick();

    // Strobe held high for 300 cycles with M=7.
    MAX_STAGE  = 3'd7;
    IN_VALUE_A = 32'h0000_0040;
    IN_VALUE_B = 32'h0;
    IN_STROBE  = 1'b1;
    k = 0;
    for (int cyc = 0; cyc < 320; cyc++) begin
      if (cyc == 300) IN_STROBE = 1'b0;
      if (OUT_VALID) begin
        chk($sformatf("ovr_pulse%0d_cycle", k), cyc, 19 * k + 18);
        chk($sformatf("ovr_pulse%0d_out_a", k), OUT_VALUE_A, 32'h40);
        k++;
      end
      tick();
    end
    chk("ovr_pulses", k, 16);
    chk("ovr_sat", OVERRUN_COUNT, 255);
    chk("ovr_idle", BUSY, 0);

    // Reset in the middle of RUN_B.
    send(3'd7, 32'h0000_0123, 32'h0000_0456);
    n = 1;
    while (n < 12) begin
      tick();
      n++;
    end
    RESET_N = 1'b0;
    tick();
    RESET_N = 1'b1;
    chk("abort_busy", BUSY, 0);
    seen = 1'b0;
    repeat (25) begin
      if (OUT_VALID) seen = 1'b1;
      tick();
    end
    chk("abort_no_valid", seen, 0);
    chk("abort_out_a", OUT_VALUE_A, 0);
    chk("abort_out_b", OUT_VALUE_B, 0);
    chk("abort_ovr", OVERRUN_COUNT, 0);
    send(3'd0, 32'd5, 32'd7);
    wait_valid(n);
    chk("abort_prime_lat", n, 4);
    chk("abort_prime_out_a", OUT_VALUE_A, 32'd5);
    chk("abort_prime_out_b", OUT_VALUE_B, 32'd7);
    repeat (2) tick();

    // A strobe in the DONE cycle is dropped and counted.
    send(3'd0, 32'd5, 32'd7);
    repeat (3) tick();
    chk("done_valid", OUT_VALID, 1);
    IN_STROBE = 1'b1;
    tick();
    IN_STROBE = 1'b0;
    chk("done_ovr", OVERRUN_COUNT, 1);
    chk("done_not_accepted", BUSY, 0);
    repeat (2) tick();
    chk("done_still_idle", BUSY, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/theremin_iir_sequencer.md
THEREMIN_IIR_SEQUENCER -- requirements
Module: theremin_iir_sequencer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): DATA_BITS, 32, sample/state width; FILTER_K_SHIFT, 8, IIR coefficient shift; MAX_STAGES, 8, stage slots per channel.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- CLK  in  1  single clock; the block uses one clock.
- RESET_N  in  1  reset; synchronous and active-low.
- MAX_STAGE  in  3  number of stages less one.
- IN_STROBE  in  1  new sample pair available.
- IN_VALUE_A  in  DATA_BITS  pitch period sample.
- IN_VALUE_B  in  DATA_BITS  volume period sample.
- BUSY  out  1  high while not IDLE.
- OUT_VALID  out  1  one-cycle pulse when the outputs update.
- OUT_VALUE_A  out  DATA_BITS  filtered pitch value.
- OUT_VALUE_B  out  DATA_BITS  filtered volume value.
- OVERRUN_COUNT  out  8  dropped strobes, saturating.

Function
REQ-003 The block SHALL share one stage-update datapath across both channels and all stages: new = s + ((x - s) >>> FILTER_K_SHIFT), one update per cycle.
- Difference: signed, DATA_BITS+1 wide.
- Shift: arithmetic.
- Result: truncated to DATA_BITS.
REQ-004 The FSM SHALL have the states IDLE, LOAD, RUN_A, RUN_B, DONE.
- IDLE -> LOAD on IN_STROBE.
- LOAD -> RUN_A.
- RUN_A runs stages 0..M, then -> RUN_B.
- RUN_B runs stages 0..M, then -> DONE.
- DONE -> IDLE.
REQ-005 In LOAD the block SHALL capture IN_VALUE_A, IN_VALUE_B and MAX_STAGE (M).
- Mid-run changes to these inputs SHALL be ignored.
REQ-006 Stage s SHALL use as its input x the new output of stage s-1 from the same pass; stage 0 SHALL use the captured sample.
REQ-007 OUT_VALID SHALL assert exactly 2(M+1)+2 cycles after the cycle IN_STROBE is sampled in IDLE.
- OUT_VALUE_A/B SHALL update in that same cycle, to stage M's new value.
- Latency is 4 cycles for M=0 and 18 cycles for M=7.
REQ-008 An IN_STROBE while BUSY SHALL be dropped and SHALL increment OVERRUN_COUNT.
- OVERRUN_COUNT SHALL saturate at 255.
- An IN_STROBE in the DONE cycle also counts as dropped.
REQ-009 Priming rule: if the block is unprimed, or the captured M differs from the M of the previous pass, the pass SHALL write x directly into every stage 0..M instead of filtering.
- Timing is unchanged when priming.
- The block SHALL mark itself primed at the end of the pass.
REQ-010 Stages above M SHALL not be written.
REQ-011 OUT_VALUE_A/B SHALL hold between OUT_VALID pulses.

Reset
REQ-012 While RESET_N=0 at a CLK edge, the block SHALL reset as follows:
- FSM to IDLE.
- All stage states, OUT_VALUE_A/B and OVERRUN_COUNT to 0.
- BUSY and OUT_VALID to 0.
- Primed flag cleared; last-M to 0.
REQ-013 A reset during a run SHALL abort the run with no OUT_VALID pulse.
- The next accepted strobe SHALL prime.

Structure
REQ-014 Package theremin_sensor_pkg SHALL hold the FSM state enum typedef and the default DATA_BITS, FILTER_K_SHIFT and MAX_STAGES constants.
REQ-015 The stage arithmetic SHALL be a sub-module theremin_iir_stage_update (combinational: s, x, prime -> new).
- State storage SHALL be a 2 x MAX_STAGES register array in the sequencer.

Verification
REQ-016 Prime test: reset, then M=0, strobe with A=0x1000_0000, B=0x2000_0000 -> OUT_VALID 4 cycles later; OUT_A=0x1000_0000, OUT_B=0x2000_0000.
REQ-017 Increase test: after the prime, strobe A=0x1000_0100 (B unchanged) -> OUT_A=0x1000_0001, OUT_B=0x2000_0000.
REQ-018 Decrease test: primed at 0x1000_0000, strobe A=0x0FFF_FF00 -> OUT_A=0x0FFF_FFFF (arithmetic shift of -0x100 gives -1).
REQ-019 Overrun and latency test, with M=7:
- Strobe every cycle for 300 cycles -> OUT_VALID every 19 cycles, 18-cycle latency each.
- OVERRUN_COUNT saturates at 255.
REQ-020 Reset-abort test: deassert RESET_N during RUN_B -> no OUT_VALID and outputs 0; the next strobe with A=5 gives OUT_A=5 (primed).
REQ-021 M-change test: primed with M=0, change M to 3 mid-run (ignored), then next strobe with M=3 and A=0x40 -> OUT_A=0x40 (re-primed) after 10 cycles.
